// File: rtl/display_7s_page_mux_pkg.sv
// Shared types and helpers for the 7-segment page selector.
// Build option: DISPLAY_7S_PAGE_MUX_BLANK_EN enables page-change blanking.
package display_7s_page_mux_pkg;

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  // Wide enough for any content word; callers slice down to DW.
  localparam int BLANK_MAX_W = 1024;
  localparam logic [BLANK_MAX_W-1:0] BLANK_WORD = '0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/display_7s_dwell_timer.sv
// Tick counter: done pulses on the tick that completes max(limit,1) ticks.
// Counter self-clears on done; clr has priority over counting.
module display_7s_dwell_timer
  import display_7s_page_mux_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic          tick,
  input  logic [CW-1:0] limit,
  output logic          done
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] term;

  // Zero limit behaves as one; >= keeps a shortened limit from overrunning.
  assign term = (limit == '0) ? '0 : limit - CW'(1);
  assign done = ~clr & en & tick & (cnt >= term);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || done) begin
      cnt <= '0;
    end else if (en && tick) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/display_7s_page_mux.sv
// Registered page selector with manual load, auto-scroll and page-change pulse.
// Build option: DISPLAY_7S_PAGE_MUX_BLANK_EN blanks dis_data for BLANK_TICKS ticks per change.
module display_7s_page_mux
  import display_7s_page_mux_pkg::*;
#(
  parameter int CHANNELS    = 8,
  parameter int DW          = 80,
  parameter int SW          = 4,
  parameter int DWELL_W     = 8,
  parameter int BLANK_TICKS = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CHANNELS*DW-1:0] dis_content,
  input  logic [SW-1:0]          sel,
  input  logic                   sel_load,
  input  logic                   auto_en,
  input  logic                   tick,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [DW-1:0]          dis_data,
  output logic [SW-1:0]          page,
  output logic                   page_chg,
  output logic                   sel_err
);

  if (CHANNELS < 2 || CHANNELS > 16 || clog2(CHANNELS) > SW || BLANK_TICKS < 0 || DW < 1
      || DW > BLANK_MAX_W) begin : g_bad_param
    $error("display_7s_page_mux: illegal parameter combination");
  end

  state_t        state, state_nx;
  logic [SW-1:0] page_nx;
  logic [SW-1:0] page_inc;
  logic          chg_nx;
  logic          adv;
  logic          sel_ok;
  logic          load_ok;
  logic          tick_eff;
  logic [DW-1:0] cur_word;

  assign sel_ok   = ({1'b0, sel} < (SW+1)'(CHANNELS));
  assign load_ok  = sel_load & sel_ok;
  // Any load, valid or not, swallows a coincident tick.
  assign tick_eff = tick & ~sel_load;
  assign page_inc = (page == SW'(CHANNELS - 1)) ? '0 : page + SW'(1);

  display_7s_dwell_timer #(.CW(DWELL_W)) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (~auto_en | load_ok),
    .en      (auto_en && (state == ST_SHOW)),
    .tick    (tick_eff),
    .limit   (dwell),
    .done    (adv)
  );

`ifdef DISPLAY_7S_PAGE_MUX_BLANK_EN
  localparam int BW = (clog2(BLANK_TICKS + 1) < 1) ? 1 : clog2(BLANK_TICKS + 1);
  logic blank_done;

  display_7s_dwell_timer #(.CW(BW)) u_blank (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     ((state != ST_BLANK) | chg_nx),
    .en      (state == ST_BLANK),
    .tick    (tick_eff),
    .limit   (BW'(BLANK_TICKS)),
    .done    (blank_done)
  );
`endif

  always_comb begin
    cur_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (page == SW'(k)) cur_word = dis_content[k*DW +: DW];
    end
  end

  always_comb begin
    page_nx  = page;
    chg_nx   = 1'b0;
    state_nx = state;
    if (load_ok) begin
      page_nx = sel;
      chg_nx  = (sel != page);
    end else if (adv) begin
      page_nx = page_inc;
      chg_nx  = 1'b1;
    end
`ifdef DISPLAY_7S_PAGE_MUX_BLANK_EN
    case (state)
      ST_SHOW:  if (chg_nx) state_nx = ST_BLANK;
      ST_BLANK: if (!chg_nx && blank_done) state_nx = ST_SHOW;
      default:  state_nx = ST_SHOW;
    endcase
`else
    state_nx = ST_SHOW;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_SHOW;
      page     <= '0;
      page_chg <= 1'b0;
      sel_err  <= 1'b0;
      dis_data <= BLANK_WORD[DW-1:0];
    end else begin
      state    <= state_nx;
      page     <= page_nx;
      page_chg <= chg_nx;
      sel_err  <= sel_load & ~sel_ok;
      dis_data <= (state == ST_BLANK) ? BLANK_WORD[DW-1:0] : cur_word;
    end
  end

endmodule

// File: doc/display_7s_page_mux.md
# display_7s_page_mux

Parametrised, registered page selector for the 7-segment display path: picks one of CHANNELS display-content words and presents it to the display driver. It adds manual page loading with range checking, an auto-scroll mode that advances pages on a dwell timer driven by an external tick strobe, and a page-change pulse. It sits between the content generators and the 7-segment driver and replaces the fixed 8-way combinational selector.

## Interface
- CHANNELS, 8: number of content pages; legal range 2..16.
- DW, 80: width of one content word.
- SW, 4: width of sel and page; must satisfy 2^SW >= CHANNELS.
- DWELL_W, 8: width of the dwell-count input.
- BLANK_TICKS, 2: ticks of blanking per page change (used only with the blanking macro).
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- dis_content  in  CHANNELS*DW  flat content bus; page k occupies bits [k*DW +: DW].
- sel  in  SW  requested page for a manual load.
- sel_load  in  1  single-cycle strobe; loads sel.
- auto_en  in  1  level; 1 selects auto-scroll mode.
- tick  in  1  single-cycle timebase strobe, e.g. 1 ms.
- dwell  in  DWELL_W  ticks per page in auto mode; 0 is treated as 1.
- dis_data  out  DW  registered selected content.
- page  out  SW  current page index.
- page_chg  out  1  one-cycle pulse when page changes.
- sel_err  out  1  one-cycle pulse when sel_load carries sel >= CHANNELS.

## Operation
- Reset values: page=0, dis_data=0, page_chg=0, sel_err=0, dwell counter=0, FSM in SHOW.
- dis_data is registered every cycle from page `page`, so content changes propagate with 1-cycle latency.
- Manual load: on sel_load with sel < CHANNELS:
  - page <= sel.
  - The dwell counter clears.
  - page_chg pulses only if sel differs from page.
- Invalid load: on sel_load with sel >= CHANNELS, page holds and sel_err pulses for one cycle.
- Auto mode: while auto_en=1, each tick increments the dwell counter.
  - When the counter reaches max(dwell,1)-1 on a tick, the counter clears and page advances.
  - The advance wraps from CHANNELS-1 to 0, and page_chg pulses.
- Leaving auto mode: when auto_en falls, the counter clears and page holds.
- Entering auto mode: when auto_en rises, counting starts from 0.
- Simultaneous events:
  - sel_load and an auto advance in the same cycle: sel_load wins, and the counter clears.
  - A tick coincident with sel_load is discarded.
- Reset mid-operation: every state returns to its reset value on the next clk edge. No partial advance is kept.
- FSM states are SHOW and BLANK. BLANK is reachable only with the blanking macro compiled in. Without it, the FSM stays in SHOW.

## Timing
- Output latency: sel_load at edge n gives the new page and page_chg=1 after edge n. dis_data shows the new content after edge n+1.
- Auto advance: page updates on the edge that samples the terminal tick. With dwell=D, a page persists for exactly D ticks.
- Pulse width: page_chg and sel_err are always exactly one cycle wide.
- tick asserted on consecutive cycles counts as consecutive ticks.

## Configuration
- Macro: DISPLAY_7S_PAGE_MUX_BLANK_EN.
- With the macro defined, every page change moves the FSM SHOW->BLANK.
  - In BLANK, dis_data=0 for BLANK_TICKS ticks, then the FSM returns to SHOW with the new page's content.
  - The dwell counter does not run in BLANK.
  - A new sel_load in BLANK updates page, restarts the blank period and pulses page_chg.
- Without the macro, dis_data switches directly and BLANK_TICKS is ignored.

## Structure
- Shared package holds the SHOW/BLANK state encoding, the all-zero blank word constant and a clog2 helper for parameter checks.
- Sub-module display_7s_dwell_timer (tick counter with terminal-count pulse and clear) is natural. It is reused for the blank period.
- The top level contains the page register, FSM and output register.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with content page0=80'h1234 -> page=0, dis_data=0. One cycle after release, dis_data=80'h1234.
- Manual load: sel=5, sel_load -> page=5 and page_chg=1 for one cycle; dis_data=page5 one cycle later. Repeat sel=5 -> no page_chg.
- Invalid load: CHANNELS=6, sel=7, sel_load -> sel_err pulse; page unchanged; no page_chg.
- Auto mode: dwell=3, auto_en=1, starting page 4 of 8 -> advances every 3 ticks through 5,6,7,0. dwell=0 -> advances every tick.
- Collision: sel_load sel=2 coincides with the terminal tick on page 6 -> page=2, counter 0, a single page_chg.
- With DISPLAY_7S_PAGE_MUX_BLANK_EN and BLANK_TICKS=2: a page change gives dis_data=0 for 2 ticks, then the new content. Reset asserted in BLANK -> SHOW, page=0.
